// File: rtl/vpu_pkg.sv
// Shared SRAM geometry, read-return tag and arbiter state encodings for the
// VPU SRAM read path.
package vpu_pkg;

  localparam int SRAM_BANK_CNT_LG2   = 2;
  localparam int SRAM_BANK_DEPTH_LG2 = 10;
  localparam int SRAM_DATA_WIDTH     = 32;

  // Wide enough to name any of up to 8 requesters.
  localparam int RD_TAG_IDX_W = 3;

  // One entry of the read-latency tag pipe: which requester a return belongs to.
  typedef struct packed {
    logic                    valid;
    logic [RD_TAG_IDX_W-1:0] idx;
  } rd_tag_t;

  // Burst-lock arbiter states (used only when burst locking is built in).
  typedef enum logic {
    S_ARB  = 1'b0,
    S_LOCK = 1'b1
  } arb_state_t;

endpackage

// File: rtl/vpu_rr_arbiter.sv
// Round-robin priority selector: the first asserted request at or after the
// pointer (wrapping) wins. Purely combinational.
module vpu_rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // Circular scan from the pointer; the first hit is latched by valid_o.
  always_comb begin
    int j;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    for (int off = 0; off < N; off++) begin
      j = (int'(ptr_i) + off) % N;
      if (!valid_o && req_i[j]) begin
        valid_o  = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/vpu_sram_rd_arbiter.sv
// Shares one SRAM read port among NUM_REQ requesters with round-robin
// arbitration and a fixed-latency tag pipe that routes read returns back.
// Optional burst locking is built in when VPU_RD_ARB_LOCK_EN is defined.
module vpu_sram_rd_arbiter
  import vpu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int RD_LAT  = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_REQ-1:0]                     req_i,
  input  logic [NUM_REQ*SRAM_BANK_CNT_LG2-1:0]   rid_i,
  input  logic [NUM_REQ*SRAM_BANK_DEPTH_LG2-1:0] addr_i,
  input  logic [NUM_REQ-1:0]                     rlast_i,
  output logic [NUM_REQ-1:0]                     ack_o,
  output logic [NUM_REQ-1:0]                     rvalid_o,
  output logic [SRAM_DATA_WIDTH-1:0]             rdata_o,
  output logic                                   sram_req_o,
  output logic [SRAM_BANK_CNT_LG2-1:0]           sram_rid_o,
  output logic [SRAM_BANK_DEPTH_LG2-1:0]         sram_addr_o,
  output logic                                   sram_reb_o,
  output logic                                   sram_rlast_o,
  input  logic                                   sram_ack_i,
  input  logic                                   sram_rvalid_i,
  input  logic [SRAM_DATA_WIDTH-1:0]             sram_rdata_i,
  output logic                                   busy_o,
  output logic                                   err_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [NUM_REQ-1:0]      req_arb;
  logic [NUM_REQ-1:0]      gnt;
  logic [IDX_W-1:0]        gnt_idx;
  logic                    gnt_valid;
  logic                    accept;
  logic [RD_TAG_IDX_W-1:0] new_idx;
  rd_tag_t                 tag_q [RD_LAT];
  rd_tag_t                 tag_d [RD_LAT];
  rd_tag_t                 head;
  logic [RD_LAT-1:0]       stage_valid;
  logic                    err_q, err_d;

`ifdef VPU_RD_ARB_LOCK_EN
  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;

  // While a burst is locked, only the owner may compete for the port.
  always_comb begin
    req_arb = req_i;
    if (state_q == S_LOCK) begin
      req_arb          = '0;
      req_arb[owner_q] = req_i[owner_q];
    end
  end

  // Lock on a non-final accepted beat, release on the owner's final beat.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      S_ARB: begin
        if (accept && !rlast_i[gnt_idx]) begin
          state_d = S_LOCK;
          owner_d = gnt_idx;
        end
      end
      S_LOCK: begin
        if (accept && rlast_i[gnt_idx]) begin
          state_d = S_ARB;
        end
      end
      default: state_d = S_ARB;
    endcase
  end

  // Burst-lock state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_ARB;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end
`else
  assign req_arb = req_i;
`endif

  vpu_rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i   (req_arb),
    .ptr_i   (ptr_q),
    .gnt_o   (gnt),
    .idx_o   (gnt_idx),
    .valid_o (gnt_valid)
  );

  assign accept     = gnt_valid & sram_ack_i;
  assign ack_o      = gnt & req_i & {NUM_REQ{sram_ack_i}};
  assign sram_req_o = |req_i;
  assign sram_reb_o = ~(|req_i);
  assign rdata_o    = sram_rdata_i;

  // Forward the granted requester's beat; zeros when nobody is granted.
  always_comb begin
    sram_rid_o   = '0;
    sram_addr_o  = '0;
    sram_rlast_o = 1'b0;
    if (gnt_valid) begin
      sram_rid_o   = rid_i[int'(gnt_idx)*SRAM_BANK_CNT_LG2 +: SRAM_BANK_CNT_LG2];
      sram_addr_o  = addr_i[int'(gnt_idx)*SRAM_BANK_DEPTH_LG2 +: SRAM_BANK_DEPTH_LG2];
      sram_rlast_o = rlast_i[gnt_idx];
    end
  end

  // Next pointer is one past the winner; hold when nothing is accepted.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      if (gnt_idx == IDX_W'(NUM_REQ - 1)) ptr_d = '0;
      else                                ptr_d = gnt_idx + 1'b1;
    end
  end

  // Tag pipe shift: accepted beats enter stage 0, the head is the last stage.
  always_comb begin
    new_idx                = '0;
    new_idx[IDX_W-1:0]     = gnt_idx;
    tag_d[0].valid         = accept;
    tag_d[0].idx           = accept ? new_idx : '0;
    for (int s = 1; s < RD_LAT; s++) begin
      tag_d[s] = tag_q[s-1];
    end
  end

  assign head = tag_q[RD_LAT-1];

  // A return with no tag, or a tag with no return, latches the error.
  always_comb begin
    err_d = err_q | (sram_rvalid_i ^ head.valid);
  end

  // Return strobe goes to the requester named by the head tag.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rvalid
    assign rvalid_o[gi] = head.valid & sram_rvalid_i &
                          (head.idx == RD_TAG_IDX_W'(gi));
  end

  for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_busy
    assign stage_valid[gi] = tag_q[gi].valid;
  end

  assign busy_o = |stage_valid;
  assign err_o  = err_q;

  // Pointer, tag pipe and sticky error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      err_q <= 1'b0;
      for (int s = 0; s < RD_LAT; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      err_q <= err_d;
      for (int s = 0; s < RD_LAT; s++) begin
        tag_q[s] <= tag_d[s];
      end
    end
  end

endmodule
